// File: rtl/if_ctrl.sv
// rtl/if_ctrl.sv - IF-stage redirect/flush/stall control and trap sequencer
// Define IF_CTRL_IRQ_LATCH_EN to capture irq_req rising edges in a pending latch.
module if_ctrl (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       irq_req,
    input  logic       exc_req,
    input  logic       in_kernel,
    input  logic       eret,
    input  logic       br_taken,
    input  logic       j_taken,
    input  logic       jr_taken,
    input  logic       load_use,
    input  logic       uart_wait,
    output logic [2:0] PCSrc,
    output logic       IF_Flush,
    output logic       IF_Pause,
    output logic       ID_Flush,
    output logic       intruption,
    output logic       exception,
    output logic [1:0] ctrl_state
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_TRAP   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_KERNEL = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic       trap_exc_q, trap_exc_d;
    logic [7:0] trap_cnt_q, trap_cnt_d;
    logic       pending;

`ifdef IF_CTRL_IRQ_LATCH_EN
    logic pend_q, pend_d;
    logic irq_prev_q, irq_prev_d;

    // A rising edge counts in the same cycle so a fresh request in RUN traps on the next edge.
    assign pending = pend_q | (irq_req & ~irq_prev_q);
`else
    assign pending = irq_req;
`endif

    always_comb begin
        state_d    = state_q;
        trap_exc_d = trap_exc_q;
        trap_cnt_d = trap_cnt_q;
`ifdef IF_CTRL_IRQ_LATCH_EN
        pend_d     = pend_q;
        irq_prev_d = irq_prev_q;
`endif
        if (!uart_wait) begin
`ifdef IF_CTRL_IRQ_LATCH_EN
            pend_d     = pending;
            irq_prev_d = irq_req;
`endif
            unique case (state_q)
                ST_RUN: begin
                    if (exc_req) begin
                        // Exception wins; any pending interrupt is kept for later.
                        state_d    = ST_TRAP;
                        trap_exc_d = 1'b1;
                        trap_cnt_d = (trap_cnt_q == 8'hFF) ? trap_cnt_q : trap_cnt_q + 8'd1;
                    end else if (pending && !in_kernel) begin
                        state_d    = ST_TRAP;
                        trap_exc_d = 1'b0;
                        trap_cnt_d = (trap_cnt_q == 8'hFF) ? trap_cnt_q : trap_cnt_q + 8'd1;
`ifdef IF_CTRL_IRQ_LATCH_EN
                        pend_d     = 1'b0;
`endif
                    end
                end
                ST_TRAP:   state_d = ST_DRAIN;
                ST_DRAIN:  state_d = ST_KERNEL;
                ST_KERNEL: if (eret) state_d = ST_RUN;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= ST_RUN;
            trap_exc_q <= 1'b0;
            trap_cnt_q <= 8'd0;
`ifdef IF_CTRL_IRQ_LATCH_EN
            pend_q     <= 1'b0;
            irq_prev_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            trap_exc_q <= trap_exc_d;
            trap_cnt_q <= trap_cnt_d;
`ifdef IF_CTRL_IRQ_LATCH_EN
            pend_q     <= pend_d;
            irq_prev_q <= irq_prev_d;
`endif
        end
    end

    // Combinational outputs are gated by reset_b so they read zero while reset is held.
    always_comb begin
        PCSrc = 3'b000;
        if (reset_b && state_q != ST_TRAP) begin
            if (jr_taken)     PCSrc = 3'b100;
            else if (j_taken) PCSrc = 3'b010;
            else if (br_taken) PCSrc = 3'b001;
        end
        IF_Flush   = reset_b && ((PCSrc != 3'b000) || state_q == ST_TRAP);
        IF_Pause   = reset_b && load_use && !IF_Flush;
        ID_Flush   = reset_b && (state_q == ST_TRAP || state_q == ST_DRAIN);
        exception  = reset_b && state_q == ST_TRAP && trap_exc_q;
        intruption = reset_b && state_q == ST_TRAP && !trap_exc_q;
    end

    assign ctrl_state = state_q;

endmodule

// File: tb/tb_if_ctrl.sv
// tb/tb_if_ctrl.sv - self-checking bench for if_ctrl with a behavioural reference model
module tb_if_ctrl;

    logic       clk = 1'b0;
    logic       reset_b = 1'b0;
    logic       irq_req, exc_req, in_kernel, eret;
    logic       br_taken, j_taken, jr_taken, load_use, uart_wait;
    logic [2:0] PCSrc;
    logic       IF_Flush, IF_Pause, ID_Flush, intruption, exception;
    logic [1:0] ctrl_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_ctrl dut (
        .clk(clk), .reset_b(reset_b), .irq_req(irq_req), .exc_req(exc_req),
        .in_kernel(in_kernel), .eret(eret), .br_taken(br_taken), .j_taken(j_taken),
        .jr_taken(jr_taken), .load_use(load_use), .uart_wait(uart_wait),
        .PCSrc(PCSrc), .IF_Flush(IF_Flush), .IF_Pause(IF_Pause), .ID_Flush(ID_Flush),
        .intruption(intruption), .exception(exception), .ctrl_state(ctrl_state)
    );

    // Model: phase 0=RUN 1=TRAP 2=DRAIN 3=KERNEL, trap cause, saturating trap count.
    int m_state = 0;
    bit m_kind_exc = 0;
    int m_cnt = 0;
    bit m_pend = 0;
    bit m_prev = 0;
    bit want_irq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        irq_req = 0; exc_req = 0; in_kernel = 0; eret = 0;
        br_taken = 0; j_taken = 0; jr_taken = 0; load_use = 0; uart_wait = 0;
    endtask

    always @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            m_state = 0; m_kind_exc = 0; m_cnt = 0; m_pend = 0; m_prev = 0;
        end else if (!uart_wait) begin
`ifdef IF_CTRL_IRQ_LATCH_EN
            if (irq_req && !m_prev) m_pend = 1;
            m_prev = irq_req;
            want_irq = m_pend;
`else
            want_irq = irq_req;
`endif
            if (m_state == 0) begin
                if (exc_req || (want_irq && !in_kernel)) begin
                    m_kind_exc = exc_req;
                    m_state = 1;
                    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                    if (!exc_req) m_pend = 0;
                end
            end else if (m_state == 3) begin
                if (eret) m_state = 0;
            end else begin
                m_state = m_state + 1;
            end
        end
    end

    logic [2:0] e_pc;
    logic       e_flush;

    always @(negedge clk) begin
        #2;
        if (!reset_b || m_state == 1) e_pc = 3'b000;
        else if (jr_taken)            e_pc = 3'b100;
        else if (j_taken)             e_pc = 3'b010;
        else if (br_taken)            e_pc = 3'b001;
        else                          e_pc = 3'b000;
        e_flush = reset_b && (e_pc != 0 || m_state == 1);
        chk("cmp_pcsrc", PCSrc, e_pc);
        chk("cmp_if_flush", IF_Flush, e_flush);
        chk("cmp_if_pause", IF_Pause, reset_b && load_use && !e_flush);
        chk("cmp_id_flush", ID_Flush, reset_b && (m_state == 1 || m_state == 2));
        chk("cmp_exception", exception, m_state == 1 && m_kind_exc);
        chk("cmp_intruption", intruption, m_state == 1 && !m_kind_exc);
        chk("cmp_state", ctrl_state, m_state);
        chk("cmp_trap_cnt", dut.trap_cnt_q, m_cnt);
    end

    initial begin
        clear_inputs();
        reset_b = 0; j_taken = 1; jr_taken = 1; load_use = 1;
        @(negedge clk); #3;
        chk("rst_pcsrc", PCSrc, 0);
        chk("rst_if_flush", IF_Flush, 0);
        chk("rst_if_pause", IF_Pause, 0);
        chk("rst_state", ctrl_state, 0);
        chk("rst_cnt", dut.trap_cnt_q, 0);
        @(negedge clk); clear_inputs(); reset_b = 1;

        @(negedge clk); j_taken = 1; load_use = 1; #3;
        chk("j_pcsrc", PCSrc, 3'b010);
        chk("j_if_flush", IF_Flush, 1);
        chk("j_if_pause", IF_Pause, 0);
        @(negedge clk); j_taken = 0; br_taken = 1; #3;
        chk("br_ld_pcsrc", PCSrc, 3'b001);
        chk("br_ld_pause", IF_Pause, 0);
        @(negedge clk); br_taken = 0; #3;
        chk("ld_pcsrc", PCSrc, 3'b000);
        chk("ld_pause", IF_Pause, 1);

        @(negedge clk); load_use = 0; irq_req = 1; #3;
        chk("irq_run_state", ctrl_state, 0);
        @(negedge clk); irq_req = 0; #3;
        chk("irq_trap_state", ctrl_state, 1);
        chk("irq_trap_intr", intruption, 1);
        chk("irq_trap_exc", exception, 0);
        chk("irq_trap_if_flush", IF_Flush, 1);
        chk("irq_trap_id_flush", ID_Flush, 1);
        @(negedge clk); #3;
        chk("drain_state", ctrl_state, 2);
        chk("drain_id_flush", ID_Flush, 1);
        @(negedge clk); #3;
        chk("kernel_state", ctrl_state, 3);
        chk("kernel_cnt", dut.trap_cnt_q, 1);
        eret = 1;
        @(negedge clk); eret = 0; #3;
        chk("eret_state", ctrl_state, 0);

        reset_b = 0;
        @(negedge clk); reset_b = 1;
        @(negedge clk); exc_req = 1; irq_req = 1;
        @(negedge clk); exc_req = 0; irq_req = 0; #3;
        chk("both_exc", exception, 1);
        chk("both_intr", intruption, 0);
        @(negedge clk); @(negedge clk); #3;
        chk("both_kernel", ctrl_state, 3);
        eret = 1;
        @(negedge clk); eret = 0; #3;
        chk("both_eret", ctrl_state, 0);
        @(negedge clk); #3;
`ifdef IF_CTRL_IRQ_LATCH_EN
        chk("latched_state", ctrl_state, 1);
        chk("latched_intr", intruption, 1);
        chk("latched_cnt", dut.trap_cnt_q, 2);
`else
        chk("lost_irq_state", ctrl_state, 0);
        chk("lost_irq_cnt", dut.trap_cnt_q, 1);
`endif
        repeat (3) @(negedge clk);
        eret = 1;
        @(negedge clk); eret = 0;

        @(negedge clk); irq_req = 1;
        @(negedge clk); irq_req = 0; uart_wait = 1; #3;
        chk("wait_state", ctrl_state, 1);
        chk("wait_intr", intruption, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #3;
            chk("wait_hold_state", ctrl_state, 1);
            chk("wait_hold_intr", intruption, 1);
        end
        @(negedge clk); uart_wait = 0; #3;
        chk("wait_release_state", ctrl_state, 1);
        @(negedge clk); #3;
        chk("wait_drain_state", ctrl_state, 2);

        j_taken = 1; load_use = 1; reset_b = 0; #1;
        chk("async_rst_state", ctrl_state, 0);
        chk("async_rst_pcsrc", PCSrc, 0);
        chk("async_rst_id_flush", ID_Flush, 0);
        chk("async_rst_if_flush", IF_Flush, 0);
        chk("async_rst_pause", IF_Pause, 0);
        @(negedge clk); clear_inputs(); reset_b = 1; #3;
        chk("post_rst_id_flush", ID_Flush, 0);
        chk("post_rst_if_flush", IF_Flush, 0);
        @(negedge clk); #3;
        chk("post_rst_state", ctrl_state, 0);

        @(negedge clk); exc_req = 1; eret = 1;
        repeat (1100) @(negedge clk);
        exc_req = 0; eret = 0; #3;
        chk("sat_cnt", dut.trap_cnt_q, 255);

        repeat (3000) begin
            @(negedge clk);
            reset_b   = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 7) == 0) irq_req = ~irq_req;
            exc_req   = ($urandom_range(0, 9) == 0);
            in_kernel = ($urandom_range(0, 2) == 0);
            eret      = ($urandom_range(0, 3) == 0);
            br_taken  = ($urandom_range(0, 3) == 0);
            j_taken   = ($urandom_range(0, 3) == 0);
            jr_taken  = ($urandom_range(0, 3) == 0);
            load_use  = ($urandom_range(0, 2) == 0);
            uart_wait = ($urandom_range(0, 7) == 0);
        end
        @(negedge clk); #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_ctrl.md
IF_CTRL -- requirements
Module: if_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_b, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port irq_req, input, 1, external interrupt request (level).
REQ-004 SHALL have port exc_req, input, 1, exception request from ID (undefined opcode), one-cycle pulse.
REQ-005 SHALL have port in_kernel, input, 1, bit 31 of the PC currently in IF.
REQ-006 SHALL have port eret, input, 1, jr in ID targeting a PC with bit 31 clear.
REQ-007 SHALL have ports br_taken / j_taken / jr_taken, input, 1 each, redirect decisions from ID/EX.
REQ-008 SHALL have port load_use, input, 1, load-use hazard detected in ID.
REQ-009 SHALL have port uart_wait, input, 1, global freeze.
REQ-010 SHALL have port PCSrc, output, 3, one-hot {JR, J, B} to IF.
REQ-011 SHALL have ports IF_Flush / IF_Pause / ID_Flush, output, 1 each.
REQ-012 SHALL have ports intruption / exception, output, 1 each, trap-vector selects to IF.
REQ-013 SHALL have port ctrl_state, output, 2, current FSM state.

Function
REQ-014 SHALL implement FSM RUN(0), TRAP(1), DRAIN(2), KERNEL(3).
REQ-015 In RUN, exc_req, or a pending interrupt with in_kernel=0, SHALL move the FSM to TRAP on the next edge.
REQ-016 TRAP SHALL last exactly one cycle, driving exception=1 if the trap came from exc_req, otherwise intruption=1; never both. Exception wins a simultaneous request and the interrupt stays pending.
REQ-017 TRAP SHALL drive IF_Flush=1 and ID_Flush=1, then go to DRAIN.
REQ-018 DRAIN SHALL last one cycle with ID_Flush=1, then go to KERNEL.
REQ-019 KERNEL SHALL ignore irq_req and SHALL return to RUN on the edge after eret=1. exc_req in KERNEL SHALL be dropped.
REQ-020 PCSrc SHALL be combinational: 100 if jr_taken, else 010 if j_taken, else 001 if br_taken, else 000. It SHALL be forced to 000 in TRAP.
REQ-021 IF_Flush SHALL be 1 whenever PCSrc is non-zero or the state is TRAP.
REQ-022 IF_Pause SHALL equal load_use, except it SHALL be 0 when IF_Flush=1 (redirect beats stall).
REQ-023 While uart_wait=1, the FSM, pending latch and counter SHALL hold, and intruption/exception SHALL be held at their current values.
REQ-024 An 8-bit trap counter SHALL increment on each TRAP entry and saturate at 255. It is readable only via hierarchy for verification.

Reset
REQ-025 When reset_b=0, the block SHALL asynchronously set state=RUN, clear the pending latch and counter, and drive all outputs to 0 (PCSrc=000).
REQ-026 Reset asserted in TRAP or DRAIN SHALL abort the sequence with no residual flush after release.

Configuration
REQ-027 Macro IF_CTRL_IRQ_LATCH_EN SHALL select interrupt capture.
REQ-028 With the macro defined, an irq_req rising edge SHALL set a pending latch, cleared on TRAP entry for that interrupt. Interrupts arriving in KERNEL or during uart_wait are taken after eret.
REQ-029 Without the macro, pending SHALL equal the live irq_req. An interrupt deasserted before RUN with in_kernel=0 is lost.

Verification
REQ-030 Reset, then j_taken=1 for one cycle -> PCSrc=010, IF_Flush=1, IF_Pause=0 in that cycle.
REQ-031 irq_req=1 in RUN with in_kernel=0 -> next cycle TRAP with intruption=1, IF_Flush=1, ID_Flush=1. Then DRAIN, then KERNEL; counter=1.
REQ-032 exc_req and irq_req in the same cycle -> exception=1, intruption=0. After eret, with the latch enabled, a second TRAP with intruption=1 follows; counter=2.
REQ-033 load_use=1 with br_taken=1 -> IF_Pause=0, PCSrc=001. load_use alone -> IF_Pause=1, PCSrc=000.
REQ-034 uart_wait=1 held 5 cycles while in TRAP -> state stays 1 and intruption stays 1. After release, DRAIN follows.
REQ-035 reset_b pulsed low in DRAIN -> ctrl_state=0 and all outputs 0 immediately, asynchronously of clk.
